// File: rtl/uno_draw_arbiter.sv
// -----------------------------------------------------------------------------
// uno_draw_arbiter
//
// Sequences the shuffled deck for one game: requests a shuffle, deals the
// opening hands round-robin, then serves single-card draw requests from the
// players in round-robin order. Reshuffles when the deck is exhausted.
//
// Optional feature (macro UNO_FLIP_START_EN): after the deal, one extra card
// is flipped onto the discard pile (o_card_player = 7, no grant).
//
// Ports:
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_start           pulse: start a new game (aborts anything in progress)
//   o_shuffle_start   pulse to the shuffler
//   i_shuffle_done    pulse from the shuffler, deck valid from this cycle
//   o_deck_idx        deck read index (draw pointer)
//   i_card            deck[o_deck_idx], combinational
//   i_req             per-player draw request, level
//   o_grant           one-hot grant, qualified by o_card_valid
//   o_card_valid      o_card delivered to o_card_player this cycle
//   o_card            delivered card (registered, held between deliveries)
//   o_card_player     receiving player (7 = discard pile)
//   o_dealing         high in S_DEAL
//   o_ready           high in S_SERVE
//   o_cards_left      DECK_SIZE minus the draw pointer
// -----------------------------------------------------------------------------
module uno_draw_arbiter #(
    parameter int NUM_PLAYERS = 4,
    parameter int DECK_SIZE   = 108,
    parameter int HAND_INIT   = 7,
    parameter int CARD_W      = 6
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    output logic                   o_shuffle_start,
    input  logic                   i_shuffle_done,
    output logic [6:0]             o_deck_idx,
    input  logic [CARD_W-1:0]      i_card,
    input  logic [NUM_PLAYERS-1:0] i_req,
    output logic [NUM_PLAYERS-1:0] o_grant,
    output logic                   o_card_valid,
    output logic [CARD_W-1:0]      o_card,
    output logic [2:0]             o_card_player,
    output logic                   o_dealing,
    output logic                   o_ready,
    output logic [6:0]             o_cards_left
);

    localparam logic [6:0] DECK_END    = 7'(DECK_SIZE);
    localparam logic [6:0] DEAL_LAST   = 7'(NUM_PLAYERS * HAND_INIT - 1);
    localparam logic [2:0] LAST_PLAYER = 3'(NUM_PLAYERS - 1);
    localparam logic [3:0] NP4         = 4'(NUM_PLAYERS);

`ifdef UNO_FLIP_START_EN
    typedef enum logic [2:0] {
        S_IDLE, S_SHUF_REQ, S_SHUF_WAIT, S_DEAL, S_FLIP, S_SERVE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_SHUF_REQ, S_SHUF_WAIT, S_DEAL, S_SERVE
    } state_t;
`endif

    state_t                   state_q, state_d;
    logic [6:0]               ptr_q, ptr_d;
    logic [2:0]               last_q, last_d;
    logic [6:0]               deal_cnt_q, deal_cnt_d;
    logic [2:0]               deal_player_q, deal_player_d;
    logic                     deal_flag_q, deal_flag_d;
    logic [NUM_PLAYERS-1:0]   grant_q, grant_d;
    logic                     valid_q, valid_d;
    logic [CARD_W-1:0]        card_q, card_d;
    logic [2:0]               player_q, player_d;

    logic                     found;
    logic [2:0]               winner;
    logic [7:0]               req_ext;
    logic [3:0]               idx;

    function automatic logic [NUM_PLAYERS-1:0] onehot(input logic [2:0] p);
        logic [NUM_PLAYERS-1:0] r;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            r[k] = (3'(k) == p);
        end
        return r;
    endfunction

    // Pointer saturates at DECK_SIZE so it can never wrap into stale cards.
    function automatic logic [6:0] ptr_inc(input logic [6:0] p);
        return (p >= DECK_END) ? p : p + 7'd1;
    endfunction

    // Round-robin search starting just above the last winner.
    always_comb begin
        found   = 1'b0;
        winner  = 3'd0;
        req_ext = 8'(i_req);
        idx     = 4'd0;
        for (int i = 1; i <= NUM_PLAYERS; i++) begin
            idx = {1'b0, last_q} + 4'(i);
            if (idx >= NP4) begin
                idx = idx - NP4;
            end
            if (!found && req_ext[idx[2:0]]) begin
                found  = 1'b1;
                winner = idx[2:0];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        last_d        = last_q;
        deal_cnt_d    = deal_cnt_q;
        deal_player_d = deal_player_q;
        deal_flag_d   = deal_flag_q;
        grant_d       = '0;
        valid_d       = 1'b0;
        card_d        = card_q;
        player_d      = player_q;

        // A new game pre-empts every state; the card that would have been
        // delivered this cycle is dropped.
        if (i_start && state_q != S_IDLE) begin
            state_d     = S_SHUF_REQ;
            deal_flag_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_d     = S_SHUF_REQ;
                        deal_flag_d = 1'b1;
                    end
                end
                S_SHUF_REQ: begin
                    state_d = S_SHUF_WAIT;
                end
                S_SHUF_WAIT: begin
                    if (i_shuffle_done) begin
                        ptr_d = 7'd0;
                        if (deal_flag_q) begin
                            state_d       = S_DEAL;
                            deal_flag_d   = 1'b0;
                            deal_cnt_d    = 7'd0;
                            deal_player_d = 3'd0;
                        end else begin
                            state_d = S_SERVE;
                        end
                    end
                end
                S_DEAL: begin
                    valid_d       = 1'b1;
                    card_d        = i_card;
                    player_d      = deal_player_q;
                    grant_d       = onehot(deal_player_q);
                    ptr_d         = ptr_inc(ptr_q);
                    deal_cnt_d    = deal_cnt_q + 7'd1;
                    deal_player_d = (deal_player_q == LAST_PLAYER) ? 3'd0
                                                                   : deal_player_q + 3'd1;
                    if (deal_cnt_q == DEAL_LAST) begin
`ifdef UNO_FLIP_START_EN
                        state_d = S_FLIP;
`else
                        state_d = S_SERVE;
`endif
                    end
                end
`ifdef UNO_FLIP_START_EN
                S_FLIP: begin
                    // Starting discard is flipped unconditionally, wilds included.
                    valid_d  = 1'b1;
                    card_d   = i_card;
                    player_d = 3'd7;
                    ptr_d    = ptr_inc(ptr_q);
                    state_d  = S_SERVE;
                end
`endif
                S_SERVE: begin
                    // Exhaustion wins over arbitration; pending requests stay
                    // asserted and are served after the reshuffle.
                    if (ptr_q >= DECK_END) begin
                        state_d     = S_SHUF_REQ;
                        deal_flag_d = 1'b0;
                    end else if (found) begin
                        valid_d  = 1'b1;
                        card_d   = i_card;
                        player_d = winner;
                        grant_d  = onehot(winner);
                        ptr_d    = ptr_inc(ptr_q);
                        last_d   = winner;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            ptr_q         <= 7'd0;
            last_q        <= LAST_PLAYER;
            deal_cnt_q    <= 7'd0;
            deal_player_q <= 3'd0;
            deal_flag_q   <= 1'b0;
            grant_q       <= '0;
            valid_q       <= 1'b0;
            card_q        <= '0;
            player_q      <= 3'd0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            last_q        <= last_d;
            deal_cnt_q    <= deal_cnt_d;
            deal_player_q <= deal_player_d;
            deal_flag_q   <= deal_flag_d;
            grant_q       <= grant_d;
            valid_q       <= valid_d;
            card_q        <= card_d;
            player_q      <= player_d;
        end
    end

    assign o_shuffle_start = (state_q == S_SHUF_REQ);
    assign o_deck_idx      = ptr_q;
    assign o_grant         = grant_q;
    assign o_card_valid    = valid_q;
    assign o_card          = card_q;
    assign o_card_player   = player_q;
    assign o_dealing       = (state_q == S_DEAL);
    assign o_ready         = (state_q == S_SERVE);
    assign o_cards_left    = DECK_END - ptr_q;

endmodule

// File: doc/uno_draw_arbiter.md
Name: uno_draw_arbiter

Overview:
- Sequences the shuffled 108-card deck for the game. It requests a shuffle, deals the opening hands, then serves single-card draw requests from players in round-robin order.
- Reads the deck through an index/card read port: o_deck_idx drives a combinational mux on the deck array, which returns i_card.
- Tracks the draw pointer and triggers a reshuffle when the deck is exhausted.
- Sits between the deck/shuffler and the per-player game logic.

Parameters:
- NUM_PLAYERS, 4, number of requesters; range 2..8.
- DECK_SIZE, 108, cards in deck; NUM_PLAYERS*HAND_INIT must be < DECK_SIZE.
- HAND_INIT, 7, cards dealt to each player at game start.
- CARD_W, 6, card encoding width: {color[1:0], value[3:0]}.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle pulse: begin a new game (shuffle, then deal).
- o_shuffle_start  out  1  one-cycle pulse to the deck shuffler.
- i_shuffle_done  in  1  one-cycle pulse from the shuffler; the deck is valid from this cycle.
- o_deck_idx  out  7  deck read index; equals the draw pointer.
- i_card  in  CARD_W  deck[o_deck_idx], combinational, same cycle.
- i_req  in  NUM_PLAYERS  draw request per player; level, held until granted.
- o_grant  out  NUM_PLAYERS  one-hot, one cycle, together with o_card_valid.
- o_card_valid  out  1  one cycle: o_card is delivered to o_card_player.
- o_card  out  CARD_W  delivered card, registered.
- o_card_player  out  3  index of the receiving player.
- o_dealing  out  1  high while in S_DEAL.
- o_ready  out  1  high in S_SERVE only.
- o_cards_left  out  7  DECK_SIZE minus the draw pointer.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=S_IDLE; pointer=0; last-grant=NUM_PLAYERS-1; deal counter=0.
  - All outputs 0, except o_cards_left=DECK_SIZE.
- States:
  - S_IDLE: i_start -> S_SHUF_REQ with a deal flag set. i_req is ignored.
  - S_SHUF_REQ: o_shuffle_start=1 for exactly one cycle -> S_SHUF_WAIT.
  - S_SHUF_WAIT: wait for i_shuffle_done. Then pointer=0 and go to S_DEAL if the deal flag is set, else S_SERVE. The deal flag clears when S_DEAL is entered.
  - S_DEAL: one card per cycle. Player = deal counter mod NUM_PLAYERS; counter 0 -> player 0, counter 1 -> player 1, ... Each cycle: o_card<=i_card, o_card_player<=player, o_grant<=one-hot(player), o_card_valid<=1, pointer++. After NUM_PLAYERS*HAND_INIT cards -> S_SERVE. i_req is ignored and stays pending.
  - S_SERVE:
    - If any i_req bit is set, pick the first set bit searching upward from last-grant+1, wrapping modulo NUM_PLAYERS.
    - On the next edge: registered o_grant/o_card_valid/o_card/o_card_player, pointer++, last-grant=winner.
    - Latency is 1 cycle from the sampled request to the grant.
    - Requesters deassert the granted bit in the grant cycle. A bit still high in the grant cycle counts as a new request, which allows back-to-back draws (e.g. draw-two).
    - Throughput: one card per cycle.
- Exhaustion: after the card at pointer DECK_SIZE-1 is delivered, pointer=DECK_SIZE and o_cards_left=0.
  - Next state is S_SHUF_REQ with the deal flag clear.
  - Pending requests are held and served after i_shuffle_done.
  - The exhaustion check takes priority over arbitration in the same cycle.
- i_start in any state other than S_IDLE:
  - Abort to S_SHUF_REQ with the deal flag set.
  - Any card not yet delivered is not delivered.
  - i_start in S_SHUF_REQ or S_SHUF_WAIT restarts the shuffle request.
- i_shuffle_done outside S_SHUF_WAIT: ignored.
- o_grant, o_card_valid: default 0 every cycle; never two grants in one cycle.
- o_card, o_card_player: hold their last value when o_card_valid=0.
- Pointer is 7 bits, saturates at DECK_SIZE, never wraps past it.

Optional Feature:
- Macro: UNO_FLIP_START_EN.
- Defined:
  - After the last dealt card, one extra cycle in state S_FLIP.
  - Delivers deck[pointer] with o_card_valid=1, o_grant=0, o_card_player=7 (discard pile); pointer++ -> S_SERVE.
  - If the flipped card value is 4'd13 or 4'd14 (wild), it is still flipped (no redraw).
- Undefined:
  - S_FLIP is absent; S_DEAL -> S_SERVE directly.
  - The initial discard is supplied externally.

Test Plan:
- Reset, then i_start; shuffler returns i_shuffle_done 5 cycles after o_shuffle_start -> exactly 28 o_card_valid pulses, players 0,1,2,3 repeating; cards equal deck[0..27]; o_cards_left=80; o_ready=1.
- In S_SERVE, i_req=4'b1111 held for 8 cycles -> grants 0,1,2,3,0,1,2,3 (last-grant reset = 3), one per cycle, pointer 28->36.
- Only player 2 holds i_req for 3 cycles -> o_grant=4'b0100 on 3 consecutive cycles, cards deck[28..30].
- Drive pointer to 107 with requests pending -> card 107 delivered, o_cards_left=0, o_shuffle_start pulses; no grant until i_shuffle_done; then the pending request is served from deck[0].
- i_start pulsed mid-deal at card 10 -> o_shuffle_start next cycle; after done, a full 28-card deal restarts from player 0, pointer 0.
- With UNO_FLIP_START_EN defined: the 29th valid pulse has o_card_player=7, o_grant=0, card deck[28]; the first player draw then receives deck[29].
